// File: rtl/data_mem_responder.sv
// Multi-cycle word data memory behind a request/acknowledge port.
// Each access waits WAIT_CYCLES before it commits. Misaligned accesses are flagged, not performed.
module data_mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 5,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        Req,
    input  logic        We,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata,
    output logic        Ack,
    output logic        Err,
    output logic        Busy
);

    localparam int            Depth   = 1 << DEPTH_LOG2;
    localparam int            AddrW   = DEPTH_LOG2 + 2;
    localparam logic [3:0]    WaitCnt = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        mem_q [Depth];
    logic               mem_we;
    logic [DEPTH_LOG2-1:0] idx;
    logic               misaligned;

    // Only the word-index and byte-offset bits are kept; higher bits alias.
    assign idx        = addr_q[AddrW-1:2];
    assign misaligned = |addr_q[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            StIdle: begin
                if (Req) begin
                    addr_d  = Addr[AddrW-1:0];
                    we_d    = We;
                    wdata_d = Wdata;
                    cnt_d   = WaitCnt;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ack_d   = 1'b1;
                    state_d = StResp;
                    if (misaligned) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (we_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx];
                    end
                end
            end
            StResp: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            if (mem_we) begin
                mem_q[idx] <= wdata_q;
            end
        end
    end

    assign Rdata = rdata_q;
    assign Ack   = ack_q;
    assign Err   = err_q;
    assign Busy  = Req & ~ack_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with two wait states and one with none, sharing clock and reset.
module tb_data_mem_responder;

    localparam int unsigned WA = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_a, req_b;
    logic        we_s;
    logic [31:0] addr_s, wdata_s;
    logic [31:0] rdata_a, rdata_b;
    logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_LOG2(5), .WAIT_CYCLES(WA)) u_dut_a (
        .Clk(clk), .Clr(clr), .Req(req_a), .We(we_s), .Addr(addr_s), .Wdata(wdata_s),
        .Rdata(rdata_a), .Ack(ack_a), .Err(err_a), .Busy(busy_a)
    );

    data_mem_responder #(.DEPTH_LOG2(5), .WAIT_CYCLES(0)) u_dut_b (
        .Clk(clk), .Clr(clr), .Req(req_b), .We(we_s), .Addr(addr_s), .Wdata(wdata_s),
        .Rdata(rdata_b), .Ack(ack_b), .Err(err_b), .Busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with dut_a idle; returns just after the edge ending RESP.
    // Operands are scrambled once sampled to show they are ignored outside IDLE.
    task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err);
        req_a   = 1'b1;
        we_s    = we;
        addr_s  = addr;
        wdata_s = wdata;
        for (int c = 0; c <= int'(WA) + 2; c++) begin
            @(negedge clk);
            if (c < int'(WA) + 2) begin
                check_eq({tag, " busy"}, 32'(busy_a), 32'd1);
                check_eq({tag, " ack early"}, 32'(ack_a), 32'd0);
                check_eq({tag, " err early"}, 32'(err_a), 32'd0);
            end else begin
                check_eq({tag, " ack"}, 32'(ack_a), 32'd1);
                check_eq({tag, " busy at ack"}, 32'(busy_a), 32'd0);
                check_eq({tag, " err"}, 32'(err_a), 32'(exp_err));
                check_eq({tag, " rdata"}, rdata_a, exp_rdata);
            end
            @(posedge clk);
            #1;
            if (c < int'(WA) + 2) begin
                we_s    = ~we;
                addr_s  = ~addr;
                wdata_s = ~wdata;
            end else begin
                req_a = 1'b0;
            end
        end
    endtask

    initial begin
        clr     = 1'b1;
        req_a   = 1'b0;
        req_b   = 1'b0;
        we_s    = 1'b0;
        addr_s  = '0;
        wdata_s = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset ack", 32'(ack_a), 32'd0);
        check_eq("reset err", 32'(err_a), 32'd0);
        check_eq("reset rdata", rdata_a, 32'd0);
        check_eq("reset busy", 32'(busy_a), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        run_txn("ld 0c", 1'b0, 32'h0000_000C, 32'h0, 32'h0, 1'b0);
        run_txn("st 10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        run_txn("ld 10", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        run_txn("st 04", 1'b1, 32'h0000_0004, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
        run_txn("ld 84", 1'b0, 32'h0000_0084, 32'h0, 32'h1234_5678, 1'b0);
        run_txn("st 00", 1'b1, 32'h0000_0000, 32'h0000_0001, 32'h1234_5678, 1'b0);
        run_txn("ld 06", 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1'b1);
        run_txn("ld 04a", 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 1'b0);
        run_txn("st 05", 1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0, 1'b1);
        run_txn("ld 04b", 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 1'b0);
        run_txn("ld 00", 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0001, 1'b0);

        // Store aborted by reset one cycle after it is accepted.
        req_a   = 1'b1;
        we_s    = 1'b1;
        addr_s  = 32'h0000_0008;
        wdata_s = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        clr   = 1'b1;
        req_a = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("abort no ack", 32'(ack_a), 32'd0);
        end
        check_eq("abort rdata", rdata_a, 32'd0);
        @(posedge clk);
        #1;
        run_txn("ld 08 abort", 1'b0, 32'h0000_0008, 32'h0, 32'h0, 1'b0);
        run_txn("ld 10 cleared", 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b0);

        // Zero wait states: one store, then three loads with Req held high throughout.
        req_b   = 1'b1;
        we_s    = 1'b1;
        addr_s  = 32'h0000_0008;
        wdata_s = 32'hCAFE_0001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("w0 st ack", 32'(ack_b), (c == 2) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        req_b  = 1'b1;
        we_s   = 1'b0;
        addr_s = 32'h0000_0008;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check_eq("w0 ld ack", 32'(ack_b),
                     (c == 2 || c == 5 || c == 8) ? 32'd1 : 32'd0);
            check_eq("w0 ld busy", 32'(busy_b),
                     (c == 2 || c == 5 || c == 8) ? 32'd0 : 32'd1);
            check_eq("w0 ld err", 32'(err_b), 32'd0);
            if (c == 2) check_eq("w0 ld1 rdata", rdata_b, 32'hCAFE_0001);
            if (c == 5) check_eq("w0 ld2 rdata", rdata_b, 32'h0);
            if (c == 8) check_eq("w0 ld3 rdata", rdata_b, 32'hCAFE_0001);
            @(posedge clk);
            #1;
            if (c == 2) addr_s = 32'h0000_000C;
            if (c == 5) addr_s = 32'h0000_0008;
            if (c == 8) req_b = 1'b0;
        end
        @(negedge clk);
        check_eq("w0 idle ack", 32'(ack_b), 32'd0);
        check_eq("w0 idle busy", 32'(busy_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that sits on the far side of the pipeline's MEM-stage load/store port. It replaces the zero-latency data memory with a request/acknowledge slave. It holds each transaction for a configurable number of wait states and raises `Busy` so the pipeline can stall MEM and the stages upstream. Word storage is internal, and misaligned accesses are reported rather than performed.

## Interface
Parameters:
- `DEPTH_LOG2`, default 5: number of address bits that index the memory. Depth is 2^DEPTH_LOG2 32-bit words.
- `WAIT_CYCLES`, default 2: wait states inserted before each access commits. Legal range is 0..15.

Ports:
- `Clk`, input, 1: the single clock. All state updates on the rising edge.
- `Clr`, input, 1: reset, synchronous and active-high.
- `Req`, input, 1: access request from the MEM stage.
- `We`, input, 1: 1 = store, 0 = load. Valid while `Req` is high.
- `Addr`, input, 32: byte address of the access.
- `Wdata`, input, 32: store data.
- `Rdata`, output, 32: load data, registered.
- `Ack`, output, 1: single-cycle completion pulse.
- `Err`, output, 1: misaligned-access flag, valid only while `Ack` is high.
- `Busy`, output, 1: stall request to the pipeline. Combinational: `Req & ~Ack`.

## Operation
- State machine with 3 states:
  - IDLE:
    - `Req`=1 at an edge: latch `Addr`, `We`, `Wdata`; load `cnt` with `WAIT_CYCLES`; go to ACCESS.
    - `Req`=0: stay in IDLE.
  - ACCESS:
    - `cnt`≠0 at an edge: decrement `cnt`.
    - `cnt`=0 at an edge: commit the access, set `Ack`=1, go to RESP.
  - RESP:
    - On the next edge, unconditionally clear `Ack` and `Err` and go to IDLE.
- Commit rules:
  - Word index = latched `Addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so addresses alias modulo the depth.
  - Store: `mem[index]` takes the latched `Wdata`. `Rdata` is unchanged.
  - Load: `Rdata` takes `mem[index]`.
  - Misaligned access (latched `Addr[1:0]`≠0): memory is not touched, `Rdata` takes 0, and `Err`=1 for the `Ack` cycle.
- `Rdata` holds its value until the next load or misaligned commit.
- Inputs are sampled only in IDLE. Changes to `Addr`, `We` or `Wdata` during ACCESS or RESP have no effect.
- `Req` dropped during ACCESS: the transaction still completes and `Ack` still pulses. This is a protocol violation with defined behaviour.
- Requester rule: hold `Req` and its operands until `Ack` is seen, then drop `Req` or present the next request in the cycle after `Ack`.
- A `Req` that is still high in the RESP cycle is not sampled in RESP. It is sampled in IDLE on the following edge and starts a new transaction.

## Timing
- Reset (`Clr`=1 at an edge) sets:
  - state = IDLE, `cnt`=0
  - `Ack`=0, `Err`=0, `Rdata`=0
  - every memory word = 0
- Reset has priority over every other event. Reset during ACCESS aborts the transaction: no store is committed and no `Ack` is issued.
- Latency, counting cycle 0 as the first cycle with `Req`=1 while in IDLE:
  - `Ack` is high in cycle `WAIT_CYCLES`+2.
  - With `WAIT_CYCLES`=0, `Ack` is high in cycle 2.
- Throughput: back-to-back transactions occupy `WAIT_CYCLES`+3 cycles each (IDLE, ACCESS × (W+1), RESP).
- `Ack` is high for exactly 1 cycle per transaction. `Err` is never high without `Ack`.
- `Busy` is high from cycle 0 through cycle W+1 and low in the `Ack` cycle. It is purely combinational from `Req` and registered `Ack`.
- A load that follows a store to the same word returns the stored data; there is no bypass hazard, since transactions are serialised.

## Test plan
- Reset then load: hold `Clr`=1 for 2 cycles, then load `Addr`=0x0C with W=2 → `Busy`=1 in cycles 0–3, `Ack`=1 in cycle 4, `Rdata`=0, `Err`=0.
- Store then load: store 0xDEADBEEF to 0x10, then load 0x10 → second `Ack` has `Rdata`=0xDEADBEEF. Each transaction takes 5 cycles at W=2.
- Aliasing with `DEPTH_LOG2`=5: store 0x12345678 to 0x04, then load 0x84 → `Rdata`=0x12345678.
- Misaligned access: load 0x06 → `Ack`=1, `Err`=1, `Rdata`=0. A following store to 0x05 leaves `mem[1]` unchanged, which a later load of 0x04 confirms.
- Reset mid-operation: store 0xAAAA5555 to 0x08 and assert `Clr` in cycle 1 → no `Ack`; a subsequent load of 0x08 returns 0.
- W=0 with back-to-back requests: hold `Req`=1 continuously over 3 loads → `Ack` in cycles 2, 5, 8; `Busy` low only in those cycles.
